// File: rtl/fht_seq_ctrl.sv
// fht_seq_ctrl
// Sequencing controller for a chain of four 16-point fast-Hadamard butterfly
// stages. A serial chip stream is collected into a 16-word bank. Each full
// symbol is handed to a 192-bit load buffer. Valid tokens then walk down the
// stage chain, and the final-stage words are drained through a read-index
// handshake.
//
// Ports
//   Clk       in   chip clock
//   Reset     in   synchronous active-high reset
//   SymStart  in   symbol boundary; qualifies the first chip of a symbol
//   DinValid  in   chip strobe
//   Din       in   12-bit two's complement chip
//   LoadData  out  load buffer to stage 1; word i at [12i+11:12i]
//   StageEn   out  per-stage fire; bit k fires stage unit k+1
//   ResValid  out  final results held and undrained
//   ResSel    out  index of the final-stage word presented to the consumer
//   ResReady  in   consumer accepts the word at ResSel
//   Busy      out  any token valid or a partial symbol in collection
//   Overrun   out  sticky; a completed symbol was dropped
//   OvrClr    in   clears Overrun (a simultaneous new drop wins)
//   SymCount  out  count of fully drained symbols, wraps at 256
module fht_seq_ctrl (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         SymStart,
  input  logic         DinValid,
  input  logic [11:0]  Din,
  output logic [191:0] LoadData,
  output logic [3:0]   StageEn,
  output logic         ResValid,
  output logic [3:0]   ResSel,
  input  logic         ResReady,
  output logic         Busy,
  output logic         Overrun,
  input  logic         OvrClr,
  output logic [7:0]   SymCount
);

  logic [11:0]  bank_q [16];
  logic [179:0] bank_flat;
  logic [191:0] load_q, load_d;
  logic [3:0]   chip_cnt_q, chip_cnt_d;
  logic         synced_q, synced_d;
  logic [4:0]   v_q, v_d;
  logic [3:0]   sel_q, sel_d;
  logic         ovr_q, ovr_d;
  logic [7:0]   sym_cnt_q, sym_cnt_d;

  logic         accept, handoff, take, drop, last_rd;
  logic [3:0]   wr_idx;
  logic         en0, en1, en2, en3;

  // Words 0..14 come from the bank; word 15 is the chip arriving this cycle.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_flat
      assign bank_flat[12*gi +: 12] = bank_q[gi];
    end
  endgenerate

  // Backpressure chain: each stage may fire only if its downstream slot is
  // empty or is itself being vacated this cycle. Kept as separate scalars so
  // the backward ripple is a plain combinational chain.
  assign last_rd = v_q[4] & ResReady & (sel_q == 4'd15);
  assign en3     = v_q[3] & (~v_q[4] | last_rd);
  assign en2     = v_q[2] & (~v_q[3] | en3);
  assign en1     = v_q[1] & (~v_q[2] | en2);
  assign en0     = v_q[0] & (~v_q[1] | en1);

  always_comb begin
    accept     = DinValid & (SymStart | synced_q);
    // A symbol marker restarts collection at word 0 whether or not a chip
    // arrives with it.
    wr_idx     = SymStart ? 4'd0 : chip_cnt_q;
    handoff    = accept & (wr_idx == 4'd15);
    take       = handoff & (~v_q[0] | en0);
    drop       = handoff & ~take;

    synced_d   = synced_q | SymStart;
    chip_cnt_d = chip_cnt_q;
    if (SymStart)
      chip_cnt_d = 4'd0;
    if (accept)
      chip_cnt_d = wr_idx + 4'd1;

    load_d = take ? {Din, bank_flat} : load_q;

    v_d[0] = (v_q[0] & ~en0) | take;
    v_d[1] = (v_q[1] & ~en1) | en0;
    v_d[2] = (v_q[2] & ~en2) | en1;
    v_d[3] = (v_q[3] & ~en3) | en2;
    v_d[4] = (v_q[4] & ~last_rd) | en3;

    sel_d = sel_q;
    if (last_rd)
      sel_d = 4'd0;
    else if (v_q[4] & ResReady)
      sel_d = sel_q + 4'd1;

    sym_cnt_d = sym_cnt_q + {7'd0, last_rd};
    ovr_d     = drop | (ovr_q & ~OvrClr);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++)
        bank_q[i] <= '0;
    end else if (accept) begin
      bank_q[wr_idx] <= Din;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      load_q     <= '0;
      chip_cnt_q <= '0;
      synced_q   <= 1'b0;
      v_q        <= '0;
      sel_q      <= '0;
      ovr_q      <= 1'b0;
      sym_cnt_q  <= '0;
    end else begin
      load_q     <= load_d;
      chip_cnt_q <= chip_cnt_d;
      synced_q   <= synced_d;
      v_q        <= v_d;
      sel_q      <= sel_d;
      ovr_q      <= ovr_d;
      sym_cnt_q  <= sym_cnt_d;
    end
  end

  assign LoadData = load_q;
  assign StageEn  = {en3, en2, en1, en0};
  assign ResValid = v_q[4];
  assign ResSel   = sel_q;
  assign Busy     = (|v_q) | (synced_q & (chip_cnt_q != 4'd0));
  assign Overrun  = ovr_q;
  assign SymCount = sym_cnt_q;

endmodule

// File: tb/tb_fht_seq_ctrl.sv
// Self-checking bench for fht_seq_ctrl. A symbol-level reference model tracks
// which pipeline slots hold a symbol, the collected chips, the drain index and
// the status flags. It predicts every output each cycle.
module tb_fht_seq_ctrl;

  logic         Clk;
  logic         Reset;
  logic         SymStart;
  logic         DinValid;
  logic [11:0]  Din;
  logic [191:0] LoadData;
  logic [3:0]   StageEn;
  logic         ResValid;
  logic [3:0]   ResSel;
  logic         ResReady;
  logic         Busy;
  logic         Overrun;
  logic         OvrClr;
  logic [7:0]   SymCount;

  int checks = 0;
  int errors = 0;

  // Reference model state: slot 0 is the load buffer, slots 1..3 are the
  // stage outputs, and slot 4 holds the final results. -1 means empty.
  int           m_slot [5];
  bit           m_synced;
  int           m_cnt;
  logic [11:0]  m_bank [16];
  logic [191:0] m_load;
  int           m_sel;
  int           m_symcnt;
  bit           m_ovr;
  int           m_id;

  fht_seq_ctrl dut (
    .Clk(Clk), .Reset(Reset), .SymStart(SymStart), .DinValid(DinValid),
    .Din(Din), .LoadData(LoadData), .StageEn(StageEn), .ResValid(ResValid),
    .ResSel(ResSel), .ResReady(ResReady), .Busy(Busy), .Overrun(Overrun),
    .OvrClr(OvrClr), .SymCount(SymCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) m_slot[i] = -1;
    for (int i = 0; i < 16; i++) m_bank[i] = '0;
    m_synced = 0; m_cnt = 0; m_load = '0; m_sel = 0;
    m_symcnt = 0; m_ovr = 0;
  endfunction

  // A symbol moves forward when the slot ahead is free or is emptying now.
  function automatic logic [4:0] moves(input bit rdy);
    logic [4:0] a;
    a[4] = (m_slot[4] >= 0) && rdy && (m_sel == 15);
    for (int k = 3; k >= 0; k--)
      a[k] = (m_slot[k] >= 0) && ((m_slot[k+1] < 0) || a[k+1]);
    return a;
  endfunction

  task automatic step(input bit ss, input bit dv, input logic [11:0] d,
                      input bit rdy, input bit clr, input bit rst);
    logic [4:0] a;
    bit busy_e;
    bit drop;
    @(negedge Clk);
    SymStart = ss; DinValid = dv; Din = d; ResReady = rdy; OvrClr = clr; Reset = rst;
    #1;
    a = moves(rdy);
    busy_e = (m_synced && m_cnt != 0);
    for (int k = 0; k < 5; k++) if (m_slot[k] >= 0) busy_e = 1;
    chk("StageEn",  192'(StageEn),  192'(a[3:0]));
    chk("ResValid", 192'(ResValid), 192'(m_slot[4] >= 0));
    chk("ResSel",   192'(ResSel),   192'(m_sel));
    chk("LoadData", LoadData,       m_load);
    chk("Busy",     192'(Busy),     192'(busy_e));
    chk("Overrun",  192'(Overrun),  192'(m_ovr));
    chk("SymCount", 192'(SymCount), 192'(m_symcnt));
    if (rst) begin
      model_reset();
    end else begin
      if (m_slot[4] >= 0 && rdy) begin
        if (m_sel == 15) begin
          m_sel = 0;
          m_symcnt = (m_symcnt + 1) % 256;
        end else begin
          m_sel++;
        end
      end
      for (int k = 4; k >= 1; k--) begin
        if (a[k-1]) m_slot[k] = m_slot[k-1];
        else if (a[k]) m_slot[k] = -1;
      end
      if (a[0]) m_slot[0] = -1;
      drop = 0;
      if (ss) begin
        m_synced = 1;
        m_cnt = 0;
      end
      if (dv && m_synced) begin
        m_bank[m_cnt] = d;
        if (m_cnt == 15) begin
          if (m_slot[0] < 0) begin
            for (int i = 0; i < 16; i++) m_load[12*i +: 12] = m_bank[i];
            m_slot[0] = m_id;
            m_id++;
          end else begin
            drop = 1;
          end
        end
        m_cnt = (m_cnt + 1) % 16;
      end
      if (drop) m_ovr = 1;
      else if (clr) m_ovr = 0;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 12'h000, rdy, 0, 0);
  endtask

  initial begin
    int first_valid;
    bit reached;
    bit rdy;
    m_id = 0;
    SymStart = 0; DinValid = 0; Din = '0; ResReady = 0; OvrClr = 0; Reset = 1;
    repeat (2) @(posedge Clk);
    model_reset();

    // Reset state, then full-rate stream of three symbols
    step(0, 0, 12'h000, 0, 0, 1);
    idle(2, 1);
    for (int i = 0; i < 48; i++) step(i == 0, 1, 12'(i), 1, 0, 0);
    idle(30, 1);
    chk("FullRateSymCount", 192'(SymCount), 192'(3));
    chk("FullRateOverrun", 192'(Overrun), 192'(0));

    // Drain stall: consumer held off long enough to fill every slot
    step(0, 0, 12'h000, 0, 0, 1);
    first_valid = -1;
    for (int c = 0; c < 260; c++) begin
      rdy = (first_valid >= 0) && (c >= first_valid + 90);
      step(c == 0, c < 96, 12'(c * 3), rdy, 0, 0);
      if (first_valid < 0 && m_slot[4] >= 0) first_valid = c;
    end
    chk("StallOverrun", 192'(Overrun), 192'(1));
    chk("StallSymCount", 192'(SymCount), 192'(5));

    // Resync in the middle of a symbol
    step(0, 0, 12'h000, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(i == 0, 1, 12'(100 + i), 0, 0, 0);
    step(1, 1, 12'hABC, 0, 0, 0);
    for (int i = 1; i < 16; i++) step(0, 1, 12'(12'h200 + i), 0, 0, 0);
    idle(2, 0);
    chk("ResyncWord0", 192'(LoadData[11:0]), 192'(12'hABC));
    chk("ResyncWord15", 192'(LoadData[191:180]), 192'(12'h20F));

    // Chips before sync are ignored; gapped stream still fills a symbol
    step(0, 0, 12'h000, 1, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 12'($urandom), 1, 0, 0);
    chk("PreSyncBusy", 192'(Busy), 192'(0));
    for (int i = 0; i < 32; i++) step(i == 0, (i % 2) == 0, 12'($urandom), 1, 0, 0);
    idle(25, 1);

    // Reset while the drain index sits at 9
    step(0, 0, 12'h000, 1, 0, 1);
    for (int i = 0; i < 16; i++) step(i == 0, 1, 12'($urandom), 1, 0, 0);
    reached = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_sel == 9) begin
        reached = 1;
        break;
      end
      step(0, 0, 12'h000, 1, 0, 0);
    end
    chk("ReachSel9", 192'(reached), 192'(1));
    step(0, 0, 12'h000, 1, 0, 1);
    step(0, 0, 12'h000, 1, 0, 0);
    chk("MidDrainResetSymCount", 192'(SymCount), 192'(0));
    chk("MidDrainResetValid", 192'(ResValid), 192'(0));

    // Overrun set beats a simultaneous clear; a lone clear clears
    step(0, 0, 12'h000, 0, 0, 1);
    for (int c = 0; c < 100; c++)
      step(c == 0, c < 96, 12'($urandom), 0, (c < 96) && (m_cnt == 15), 0);
    chk("OvrSetWins", 192'(Overrun), 192'(1));
    step(0, 0, 12'h000, 0, 1, 0);
    idle(1, 0);
    chk("OvrClrAlone", 192'(Overrun), 192'(0));

    // Randomized traffic
    step(0, 0, 12'h000, 0, 0, 1);
    for (int c = 0; c < 1500; c++)
      step(($urandom % 97) == 0, ($urandom % 4) != 0, 12'($urandom),
           ($urandom % 3) != 0, ($urandom % 50) == 0, ($urandom % 700) == 0);
    idle(40, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
